pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter and execution controller that drives the combinational instruction ROM/decoder.
- Holds the PC and steps it one instruction per cycle.
- Resolves jumps and branches using the decoder's jmpLoc and the ALU compare result.
- Stalls on data-memory accesses through a req/ready handshake.
- Stops on HALT and reports completion plus a retired-instruction count.

Parameters:
PC_W, 16, program counter width (matches ROM pc input)
CNT_W, 16, retired-instruction counter width
MAX_WAIT, 8, maximum cycles a memory access may stall before timeout error (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begin execution at start_addr
start_addr  in  PC_W  first PC of program
opcode  in  4  decoded opcode from instruction ROM at current pc
jmp_loc  in  PC_W  jump/branch target from instruction ROM
branch_taken  in  1  datapath compare result for the current branch opcode
mem_ready  in  1  data memory completes the current access this cycle
pc  out  PC_W  current program counter (to ROM)
busy  out  1  high in RUN or MEM_WAIT
halted  out  1  high in HALTED
done  out  1  one-cycle registered pulse on entering HALTED
err  out  1  sticky memory-timeout flag; cleared by start
mem_req  out  1  data memory access request
mem_we  out  1  write qualifier for mem_req (STR)
reg_wen  out  1  register-file write enable for the current instruction
instr_count  out  CNT_W  retired instructions since last start

Behaviour:
- Reset (async, rst_n=0) takes effect immediately. All registered outputs are 0 and the state is IDLE:
  - pc=0, instr_count=0, err=0, done=0.
  - mem_req, mem_we, reg_wen, busy and halted all evaluate to 0.
- States: IDLE, RUN, MEM_WAIT, HALTED. Encoding is free.
- IDLE / HALTED:
  - start=1 -> pc<=start_addr, instr_count<=0, err<=0, wait counter<=0, next RUN.
  - Otherwise pc holds.
- RUN: one instruction per cycle. Opcode values: LB=0, LHB=1, JMP=2, STR=3, LIM=4, MVB=5, MVF=6, ADD=7, SUB=8, SFT=9, BNE=A, BEQ=B, BLT=C, INC=D, HALT=E, BLS=F.
  - JMP: pc<=jmp_loc.
  - BNE/BEQ/BLT/BLS: pc<=branch_taken ? jmp_loc : pc+1.
  - HALT: pc holds; next HALTED; done=1 on the following cycle.
  - LB/LHB/STR:
    - mem_req=1, mem_we=(opcode==STR).
    - If mem_ready is 1 the same cycle: pc<=pc+1, stay in RUN.
    - Else: next MEM_WAIT, wait counter<=1.
  - All others: pc<=pc+1.
- MEM_WAIT:
  - mem_req and mem_we stay asserted as for the stalled opcode, and pc holds.
  - mem_ready=1 -> pc<=pc+1, next RUN.
  - If mem_ready=0 and the wait counter equals MAX_WAIT: err<=1, next HALTED, done pulse. pc holds at the faulting instruction.
  - Otherwise the wait counter increments.
- Output timing: mem_req, mem_we, reg_wen and busy are combinational from state+opcode+mem_ready. All are 0 outside RUN/MEM_WAIT.
- reg_wen:
  - Asserted in RUN for LIM, MVB, MVF, ADD, SUB, SFT, INC.
  - For LB/LHB, asserted only in the cycle mem_req && mem_ready.
  - Never asserted for STR, JMP, branches or HALT.
- Retirement:
  - Every instruction that advances or redirects pc increments instruction_count; so does HALT.
  - A stalled cycle does not increment. A timeout does not increment.
  - instr_count saturates at all-ones.
- PC arithmetic is modulo 2^PC_W: pc+1 at all-ones wraps to 0.
- Ignored inputs:
  - start in RUN or MEM_WAIT is ignored.
  - branch_taken is ignored for non-branch opcodes.
  - mem_ready is ignored unless mem_req=1.
- done is a registered pulse: exactly one cycle, even if start arrives in the same cycle that done is high.
- rst_n asserted mid-access drops mem_req asynchronously; no partial state is retained.

Test Plan:
- Reset then start with start_addr=50, opcodes LIM, MVF, ADD, HALT -> pc goes 50,51,52,53 then holds at 53; reg_wen=1 for 3 cycles; done pulses once; instr_count=4; halted=1.
- JMP at pc=10 with jmp_loc=100 -> next pc=100. BEQ at pc=100 with branch_taken=0 -> pc=101. BEQ with branch_taken=1 and jmp_loc=10 -> pc=10.
- LB with mem_ready held low for 3 cycles:
  - mem_req=1, mem_we=0 for 4 cycles; pc stable for those cycles.
  - reg_wen=1 only on the ready cycle; then pc+1.
  - instr_count increments once.
- STR with MAX_WAIT=8 and mem_ready never asserted -> err=1 after 8 stall cycles; state HALTED; done pulse; pc stays at the STR address. A following start clears err.
- Start with start_addr=16'hFFFF and opcode ADD -> pc wraps to 0. A start pulse during RUN has no effect on pc.
- Deassert rst_n during MEM_WAIT -> pc=0, mem_req=0, busy=0 immediately, without a clock edge. The block stays IDLE until the next start.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Data-memory handshake between the program sequencer and the data memory.
// The sequencer raises mem_req (with mem_we for stores) and the memory
// answers with mem_ready in the cycle it completes the access.
interface pc_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      output mem_ready
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and execution controller for the combinational ROM/decoder.
// Steps the PC one instruction per cycle, resolves jumps/branches, stalls on
// data-memory accesses, times out stuck accesses and stops on HALT while
// counting retired instructions.
module pc_sequencer #(
   parameter int PC_W     = 16,
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [PC_W-1:0]   start_addr,
   input  logic [3:0]        opcode,
   input  logic [PC_W-1:0]   jmp_loc,
   input  logic              branch_taken,
   pc_sequencer_if.master    mem,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              halted,
   output logic              done,
   output logic              err,
   output logic              reg_wen,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   localparam logic [3:0] OP_LB   = 4'h0;
   localparam logic [3:0] OP_LHB  = 4'h1;
   localparam logic [3:0] OP_JMP  = 4'h2;
   localparam logic [3:0] OP_STR  = 4'h3;
   localparam logic [3:0] OP_LIM  = 4'h4;
   localparam logic [3:0] OP_MVB  = 4'h5;
   localparam logic [3:0] OP_MVF  = 4'h6;
   localparam logic [3:0] OP_ADD  = 4'h7;
   localparam logic [3:0] OP_SUB  = 4'h8;
   localparam logic [3:0] OP_SFT  = 4'h9;
   localparam logic [3:0] OP_BNE  = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_BLT  = 4'hC;
   localparam logic [3:0] OP_INC  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hE;
   localparam logic [3:0] OP_BLS  = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_HALTED   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic              done_q, done_d;

   logic              mem_req_c;
   logic              mem_we_c;
   logic              reg_wen_c;
   logic              retire;
   logic [PC_W-1:0]   pc_inc;

   // Next-state, PC/counter update and combinational handshake outputs
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      count_d   = count_q;
      wait_d    = wait_q;
      err_d     = err_q;
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      reg_wen_c = 1'b0;
      retire    = 1'b0;
      pc_inc    = pc_q + PC_W'(1);

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_d    = start_addr;
               err_d   = 1'b0;
               wait_d  = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            case (opcode)
               OP_JMP: begin
                  pc_d   = jmp_loc;
                  retire = 1'b1;
               end
               OP_BNE, OP_BEQ, OP_BLT, OP_BLS: begin
                  pc_d   = branch_taken ? jmp_loc : pc_inc;
                  retire = 1'b1;
               end
               OP_HALT: begin
                  state_d = S_HALTED;
                  retire  = 1'b1;
               end
               OP_LB, OP_LHB, OP_STR: begin
                  mem_req_c = 1'b1;
                  mem_we_c  = (opcode == OP_STR);
                  if (mem.mem_ready) begin
                     pc_d      = pc_inc;
                     retire    = 1'b1;
                     reg_wen_c = (opcode != OP_STR);
                  end else begin
                     state_d = S_MEM_WAIT;
                     wait_d  = WAIT_W'(1);
                  end
               end
               OP_LIM, OP_MVB, OP_MVF, OP_ADD, OP_SUB, OP_SFT, OP_INC: begin
                  pc_d      = pc_inc;
                  retire    = 1'b1;
                  reg_wen_c = 1'b1;
               end
               default: begin
                  pc_d   = pc_inc;
                  retire = 1'b1;
               end
            endcase
         end
         S_MEM_WAIT: begin
            mem_req_c = 1'b1;
            mem_we_c  = (opcode == OP_STR);
            if (mem.mem_ready) begin
               pc_d      = pc_inc;
               retire    = 1'b1;
               reg_wen_c = (opcode != OP_STR);
               state_d   = S_RUN;
            end else if (wait_q == WAIT_LIMIT) begin
               err_d   = 1'b1;
               state_d = S_HALTED;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if ((state_q == S_IDLE || state_q == S_HALTED) && start) begin
         count_d = '0;
      end else if (retire && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end

      done_d = (state_d == S_HALTED) && (state_q != S_HALTED);
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         count_q <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign mem.mem_req = mem_req_c;
   assign mem.mem_we  = mem_we_c;
   assign reg_wen     = reg_wen_c;
   assign pc          = pc_q;
   assign busy        = (state_q == S_RUN) || (state_q == S_MEM_WAIT);
   assign halted      = (state_q == S_HALTED);
   assign done        = done_q;
   assign err         = err_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. Opcodes are driven directly
// cycle by cycle in place of a ROM; the counter is narrowed to 3 bits so that
// saturation is reachable in a few instructions.
module tb_pc_sequencer;

   localparam int PC_W     = 16;
   localparam int CNT_W    = 3;
   localparam int MAX_WAIT = 8;

   localparam logic [3:0] OP_LB   = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'h2;
   localparam logic [3:0] OP_STR  = 4'h3;
   localparam logic [3:0] OP_LIM  = 4'h4;
   localparam logic [3:0] OP_MVF  = 4'h6;
   localparam logic [3:0] OP_ADD  = 4'h7;
   localparam logic [3:0] OP_BNE  = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hE;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [PC_W-1:0]  start_addr;
   logic [3:0]       opcode;
   logic [PC_W-1:0]  jmp_loc;
   logic             branch_taken;
   logic [PC_W-1:0]  pc;
   logic             busy;
   logic             halted;
   logic             done;
   logic             err;
   logic             reg_wen;
   logic [CNT_W-1:0] instr_count;

   int tests_run;
   int tests_failed;

   pc_sequencer_if mem_if ();

   pc_sequencer #(
      .PC_W     (PC_W),
      .CNT_W    (CNT_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .start_addr   (start_addr),
      .opcode       (opcode),
      .jmp_loc      (jmp_loc),
      .branch_taken (branch_taken),
      .mem          (mem_if),
      .pc           (pc),
      .busy         (busy),
      .halted       (halted),
      .done         (done),
      .err          (err),
      .reg_wen      (reg_wen),
      .instr_count  (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [PC_W-1:0] addr);
      start      = 1'b1;
      start_addr = addr;
      tick();
      start      = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      tests_run++;
      if (pc !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_pc: got %0d expected 0", pc); end
      tests_run++;
      if ({busy, halted, done, err, reg_wen, mem_if.mem_req, mem_if.mem_we} !== 7'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: got %b expected 0000000", {busy, halted, done, err, reg_wen, mem_if.mem_req, mem_if.mem_we});
      end
      tests_run++;
      if (instr_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", instr_count); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_program();
      logic [3:0] prog [3];
      int wen_cycles;
      prog[0] = OP_LIM; prog[1] = OP_MVF; prog[2] = OP_ADD;
      wen_cycles = 0;
      opcode = OP_LIM;
      do_start(16'd50);
      for (int i = 0; i < 3; i++) begin
         opcode = prog[i];
         #1;
         tests_run++;
         if (pc !== 16'(50 + i)) begin tests_failed++; $display("[TB] FAIL basic_pc%0d: got %0d expected %0d", i, pc, 50 + i); end
         if (reg_wen === 1'b1) wen_cycles++;
         tick();
      end
      opcode = OP_HALT;
      #1;
      tests_run++;
      if (pc !== 16'd53 || reg_wen !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL basic_halt_cycle: got pc=%0d wen=%b busy=%b expected pc=53 wen=0 busy=1", pc, reg_wen, busy);
      end
      tests_run++;
      if (wen_cycles != 3) begin tests_failed++; $display("[TB] FAIL basic_wen_cycles: got %0d expected 3", wen_cycles); end
      tick();
      tests_run++;
      if (halted !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || pc !== 16'd53) begin
         tests_failed++;
         $display("[TB] FAIL basic_halted: got halted=%b done=%b busy=%b pc=%0d expected 1 1 0 53", halted, done, busy, pc);
      end
      tests_run++;
      if (instr_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL basic_count: got %0d expected 4", instr_count); end
      tick();
      tests_run++;
      if (done !== 1'b0 || pc !== 16'd53 || halted !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL basic_done_pulse: got done=%b pc=%0d halted=%b expected 0 53 1", done, pc, halted);
      end
   endtask

   task automatic test_jump_branch();
      opcode = OP_JMP; jmp_loc = 16'd100; branch_taken = 1'b1;
      do_start(16'd10);
      tests_run++;
      if (reg_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL jmp_wen: got %b expected 0", reg_wen); end
      tick();
      tests_run++;
      if (pc !== 16'd100) begin tests_failed++; $display("[TB] FAIL jmp_pc: got %0d expected 100", pc); end
      opcode = OP_BEQ; branch_taken = 1'b0; jmp_loc = 16'd10;
      tick();
      tests_run++;
      if (pc !== 16'd101) begin tests_failed++; $display("[TB] FAIL beq_not_taken: got %0d expected 101", pc); end
      branch_taken = 1'b1;
      tick();
      tests_run++;
      if (pc !== 16'd10) begin tests_failed++; $display("[TB] FAIL beq_taken: got %0d expected 10", pc); end
      opcode = OP_BNE; jmp_loc = 16'd77;
      tick();
      tests_run++;
      if (pc !== 16'd77) begin tests_failed++; $display("[TB] FAIL bne_taken: got %0d expected 77", pc); end
      opcode = OP_ADD; jmp_loc = 16'd500;
      tick();
      tests_run++;
      if (pc !== 16'd78) begin tests_failed++; $display("[TB] FAIL add_ignores_branch: got %0d expected 78", pc); end
      opcode = OP_HALT; branch_taken = 1'b0;
      tick();
      tests_run++;
      if (instr_count !== 3'd6 || halted !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL branch_count: got count=%0d halted=%b expected 6 1", instr_count, halted);
      end
   endtask

   task automatic test_mem_stall();
      opcode = OP_LB; mem_if.mem_ready = 1'b0;
      do_start(16'd200);
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0 || reg_wen !== 1'b0 || pc !== 16'd200 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL lb_stall%0d: got req=%b we=%b wen=%b pc=%0d busy=%b expected 1 0 0 200 1", i, mem_if.mem_req, mem_if.mem_we, reg_wen, pc, busy);
         end
         tick();
      end
      mem_if.mem_ready = 1'b1;
      #1;
      tests_run++;
      if (mem_if.mem_req !== 1'b1 || reg_wen !== 1'b1 || pc !== 16'd200) begin
         tests_failed++;
         $display("[TB] FAIL lb_ready: got req=%b wen=%b pc=%0d expected 1 1 200", mem_if.mem_req, reg_wen, pc);
      end
      tick();
      mem_if.mem_ready = 1'b0;
      opcode = OP_HALT;
      #1;
      tests_run++;
      if (pc !== 16'd201 || instr_count !== 3'd1 || mem_if.mem_req !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL lb_retire: got pc=%0d count=%0d req=%b expected 201 1 0", pc, instr_count, mem_if.mem_req);
      end
      tick();
   endtask

   task automatic test_timeout();
      opcode = OP_STR; mem_if.mem_ready = 1'b0;
      do_start(16'd300);
      for (int i = 0; i <= MAX_WAIT; i++) begin
         tests_run++;
         if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b1 || err !== 1'b0 || pc !== 16'd300) begin
            tests_failed++;
            $display("[TB] FAIL str_stall%0d: got req=%b we=%b err=%b pc=%0d expected 1 1 0 300", i, mem_if.mem_req, mem_if.mem_we, err, pc);
         end
         tick();
      end
      tests_run++;
      if (err !== 1'b1 || halted !== 1'b1 || done !== 1'b1 || pc !== 16'd300 || busy !== 1'b0 || mem_if.mem_req !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL str_timeout: got err=%b halted=%b done=%b pc=%0d busy=%b req=%b expected 1 1 1 300 0 0", err, halted, done, pc, busy, mem_if.mem_req);
      end
      tests_run++;
      if (instr_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL str_timeout_count: got %0d expected 0", instr_count); end
      tick();
      opcode = OP_HALT;
      do_start(16'd5);
      tests_run++;
      if (err !== 1'b0 || busy !== 1'b1 || pc !== 16'd5) begin
         tests_failed++;
         $display("[TB] FAIL err_clear: got err=%b busy=%b pc=%0d expected 0 1 5", err, busy, pc);
      end
      tick();
   endtask

   task automatic test_wrap_and_ignore_start();
      opcode = OP_ADD;
      do_start(16'hFFFF);
      tests_run++;
      if (pc !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL wrap_start: got %h expected ffff", pc); end
      tick();
      tests_run++;
      if (pc !== 16'h0000) begin tests_failed++; $display("[TB] FAIL wrap_pc: got %h expected 0000", pc); end
      start = 1'b1; start_addr = 16'h1234;
      tick();
      start = 1'b0;
      tests_run++;
      if (pc !== 16'h0001) begin tests_failed++; $display("[TB] FAIL start_in_run: got %h expected 0001", pc); end
      opcode = OP_HALT;
      tick();
      tests_run++;
      if (done !== 1'b1 || instr_count !== 3'd3) begin
         tests_failed++;
         $display("[TB] FAIL wrap_halt: got done=%b count=%0d expected 1 3", done, instr_count);
      end
   endtask

   task automatic test_back_to_back();
      // continues from a HALTED state whose done pulse is high right now
      opcode = OP_ADD;
      start = 1'b1; start_addr = 16'd7;
      tick();
      start = 1'b0;
      tests_run++;
      if (done !== 1'b0 || pc !== 16'd7 || busy !== 1'b1 || instr_count !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL restart_in_done: got done=%b pc=%0d busy=%b count=%0d expected 0 7 1 0", done, pc, busy, instr_count);
      end
      for (int i = 0; i < 9; i++) tick();
      tests_run++;
      if (instr_count !== 3'd7 || pc !== 16'd16) begin
         tests_failed++;
         $display("[TB] FAIL count_saturate: got count=%0d pc=%0d expected 7 16", instr_count, pc);
      end
      opcode = OP_HALT;
      tick();
      tests_run++;
      if (instr_count !== 3'd7 || halted !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL count_saturate_halt: got count=%0d halted=%b expected 7 1", instr_count, halted);
      end
   endtask

   task automatic test_reset_mid_access();
      opcode = OP_LB; mem_if.mem_ready = 1'b0;
      do_start(16'd400);
      tick();
      tests_run++;
      if (busy !== 1'b1 || mem_if.mem_req !== 1'b1 || pc !== 16'd400) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset_wait: got busy=%b req=%b pc=%0d expected 1 1 400", busy, mem_if.mem_req, pc);
      end
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (pc !== 16'd0 || mem_if.mem_req !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got pc=%0d req=%b busy=%b expected 0 0 0", pc, mem_if.mem_req, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_if.mem_ready = 1'b1;
      tick();
      tick();
      tests_run++;
      if (pc !== 16'd0 || busy !== 1'b0 || halted !== 1'b0 || mem_if.mem_req !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_after_reset: got pc=%0d busy=%b halted=%b req=%b expected 0 0 0 0", pc, busy, halted, mem_if.mem_req);
      end
   endtask

   initial begin
      tests_run        = 0;
      tests_failed     = 0;
      rst_n            = 1'b0;
      start            = 1'b0;
      start_addr       = '0;
      opcode           = OP_ADD;
      jmp_loc          = '0;
      branch_taken     = 1'b0;
      mem_if.mem_ready = 1'b0;

      test_reset();
      test_basic_program();
      test_jump_branch();
      test_mem_stall();
      test_timeout();
      test_wrap_and_ignore_start();
      test_back_to_back();
      test_reset_mid_access();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
